pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the Tomasulo front end. It merges the PC register and next-PC selection, and adds four features: a stall input, a commit-side redirect with priority, a circular return-address stack (RAS) for call/return, and error flags. It sits between the decoder, which supplies the selector and immediates, and instruction fetch, which consumes `pc`. Commit/flush logic drives `redirect_*` on branch mispredict or exception recovery.

## Interface
- `XLEN`, 32: address width, must be ≥ 32.
- `RESET_PC`, 0: value loaded into `pc` on reset.
- `RAS_DEPTH`, 4: RAS entries, power of two, ≥ 2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `pc_en` in 1: advance enable; 0 = stall.
- `sel` in 3: next-PC mode. NEXT=0, REL=1, ABS=2, RS=3, CALL_REL=4, CALL_ABS=5, RET=6; 7 is reserved and behaves as NEXT.
- `immd16` in 16: branch offset, in words, signed.
- `immd26` in 26: jump index.
- `rs` in XLEN: register jump target.
- `redirect_valid` in 1: force `pc` to `redirect_pc`.
- `redirect_pc` in XLEN: recovery target.
- `redirect_flush_ras` in 1: together with `redirect_valid`, empties the RAS.
- `pc` out XLEN: current fetch address, registered.
- `npc` out XLEN: combinational next address per `sel`, ignoring redirect.
- `ras_count` out log2(RAS_DEPTH)+1: valid RAS entries.
- `misaligned` out 1: combinational; `npc[1:0]` ≠ 0.
- `ras_underflow` out 1: registered one-cycle pulse.

## Operation
- `seq = pc + 4`, wrapping mod 2^XLEN.
- Target for each mode:
  - NEXT: `seq`.
  - REL / CALL_REL: `seq + (sext(immd16) << 2)`, mod 2^XLEN.
  - ABS / CALL_ABS: `{pc[XLEN-1:28], immd26, 2'b00}`.
  - RS: `rs` unmodified. `misaligned` flags a bad address; the unit does not correct it.
  - RET: RAS top if `ras_count` > 0, else `seq`.
- Update priority at each edge:
  1. `redirect_valid`: `pc` ← `redirect_pc`. The RAS is cleared if `redirect_flush_ras` is set, otherwise untouched. No push or pop occurs regardless of `sel`/`pc_en`.
  2. `pc_en`: `pc` ← `npc`, and the RAS action for `sel` is applied.
  3. Otherwise `pc`, the RAS and the count hold.
- RAS is circular: storage array, top pointer `tp`, count.
  - Push (CALL_*) writes `seq` at `tp+1` and advances `tp`. The count increments, saturating at `RAS_DEPTH`. When full, the push overwrites the oldest entry.
  - Pop (RET, count > 0) decrements `tp` and the count.
  - Pop with count = 0: `npc` = `seq`, no state change, `ras_underflow` = 1 for the next cycle.
- Reserved `sel` = 7 has no RAS effect.

## Timing
- Reset, asynchronous, while `RST` is high:
  - `pc` = `RESET_PC`.
  - `ras_count` = 0, `tp` = 0.
  - `ras_underflow` = 0.
  - RAS storage contents are don't-care.
- `npc` and `misaligned` are combinational from `pc`, `sel`, the immediates, `rs` and the RAS top, with zero latency.
- `pc` updates one edge after its inputs are sampled. `npc` computed in cycle n appears on `pc` in cycle n+1.
- `ras_count` reflects a push or pop after the same edge.
- `ras_underflow` is high for exactly the cycle after the offending edge.
- Back-to-back CALL then RET: the RET in the next cycle pops the address just pushed, i.e. old `pc + 4`.
- Reset asserted mid-operation: state is cleared immediately and is held while `RST` is high. The first update occurs at the first edge after deassertion.
- Redirect and stall together: redirect wins.
- Stall with a CALL or RET selected: no RAS change.

## Structure
- Shared package (`head.v` defines) holds the `sel` encodings:
  - `NextIns`, `RelJmp`, `AbsJmp`, `RsJmp` keep their existing values 0–3.
  - Add `CallRel`, `CallAbs`, `RetJmp` as 4–6.
- Sub-module `ras_stack` (parameter `DEPTH`, `WIDTH`) provides push/pop/clear/top/count/underflow.
- `pc_unit` owns the PC register, target mux and priority logic.

## Test plan
- Reset, then release `RST` with `pc_en`=1 and `sel`=NEXT for 3 cycles → `pc` = 0, 4, 8, 12.
- `pc`=0x100, REL with `immd16`=0xFFFF → `npc` = 0x100. Then ABS with `pc`=0x40000010, `immd26`=0x10 → `pc` = 0x40000040.
- `pc`=0x200, CALL_ABS to 0x400, then RET → `pc` = 0x400, then 0x204. `ras_count` goes 1 → 0.
- `RAS_DEPTH`=4: 5 calls from `pc`s A..E, then 5 RETs → returns E+4, D+4, C+4, B+4, then `seq` with an `ras_underflow` pulse.
- `redirect_valid`=1 to 0x80 with `pc_en`=1, `sel`=CALL_REL, `redirect_flush_ras`=1 → `pc`=0x80, `ras_count`=0.
- Stall (`pc_en`=0) with RET and count = 2 → `pc`, `ras_count` unchanged. Assert `RST` mid-cycle → `pc`=`RESET_PC` before the next edge.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// ============================================================================
// Module  : pc_unit_pkg
// Brief   : Next-PC selector encodings and helpers shared by the PC unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_unit_pkg;

   typedef enum logic [2:0] {
      NextIns = 3'd0,
      RelJmp  = 3'd1,
      AbsJmp  = 3'd2,
      RsJmp   = 3'd3,
      CallRel = 3'd4,
      CallAbs = 3'd5,
      RetJmp  = 3'd6,
      SelRsvd = 3'd7
   } sel_e;

   localparam int c_insn_bytes = 4;

   function automatic logic is_call(input sel_e s);
      return (s == CallRel) || (s == CallAbs);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ras_stack.sv
// ============================================================================
// Module  : ras_stack
// Brief   : Circular return-address stack; a push when full overwrites oldest.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_stack #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     RST,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         push_data,
   output logic [WIDTH-1:0]         top,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     underflow
);

   localparam int                  c_pw    = $clog2(DEPTH);
   localparam logic [c_pw-1:0]     c_one   = 1;
   localparam logic [c_pw:0]       c_cnt1  = 1;
   localparam logic [c_pw:0]       c_full  = (c_pw+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_pw-1:0]  r_tp;
   logic [c_pw:0]    r_count;
   logic             r_underflow;

   logic             w_empty;
   logic [c_pw-1:0]  w_tp_inc;

   assign w_empty  = (r_count == '0);
   assign w_tp_inc = r_tp + c_one;

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         r_tp        <= '0;
         r_count     <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_underflow <= pop && w_empty && !clear;
         if (clear) begin
            r_tp    <= '0;
            r_count <= '0;
         end else if (push) begin
            r_tp <= w_tp_inc;
            if (r_count != c_full)
               r_count <= r_count + c_cnt1;
         end else if (pop && !w_empty) begin
            r_tp    <= r_tp - c_one;
            r_count <= r_count - c_cnt1;
         end
      end
   end

   // Storage needs no reset: an entry is only read once count says it is valid.
   always_ff @(posedge clk) begin
      if (push && !clear)
         r_mem[w_tp_inc] <= push_data;
   end

   assign top       = r_mem[r_tp];
   assign count     = r_count;
   assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module  : pc_unit
// Brief   : PC register, next-PC target mux, redirect priority and RAS control.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int              RAS_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        RST,
   input  logic                        pc_en,
   input  logic [2:0]                  sel,
   input  logic [15:0]                 immd16,
   input  logic [25:0]                 immd26,
   input  logic [XLEN-1:0]             rs,
   input  logic                        redirect_valid,
   input  logic [XLEN-1:0]             redirect_pc,
   input  logic                        redirect_flush_ras,
   output logic [XLEN-1:0]             pc,
   output logic [XLEN-1:0]             npc,
   output logic [$clog2(RAS_DEPTH):0]  ras_count,
   output logic                        misaligned,
   output logic                        ras_underflow
);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_seq;
   logic [XLEN-1:0] w_rel;
   logic [XLEN-1:0] w_abs;
   logic [XLEN-1:0] w_npc;
   logic [XLEN-1:0] w_ras_top;
   logic            w_adv;
   logic            w_push;
   logic            w_pop;
   logic            w_clear;
   sel_e            w_sel;

   assign w_sel = sel_e'(sel);
   assign w_seq = r_pc + XLEN'(c_insn_bytes);
   assign w_rel = w_seq + {{(XLEN-18){immd16[15]}}, immd16, 2'b00};
   assign w_abs = {r_pc[XLEN-1:28], immd26, 2'b00};

   always_comb begin
      w_npc = w_seq;
      case (w_sel)
         RelJmp, CallRel: w_npc = w_rel;
         AbsJmp, CallAbs: w_npc = w_abs;
         RsJmp:           w_npc = rs;
         RetJmp:          w_npc = (ras_count != '0) ? w_ras_top : w_seq;
         default:         w_npc = w_seq;
      endcase
   end

   // Redirect takes priority and suppresses any RAS push/pop for this edge.
   assign w_adv   = pc_en && !redirect_valid;
   assign w_push  = w_adv && is_call(w_sel);
   assign w_pop   = w_adv && (w_sel == RetJmp);
   assign w_clear = redirect_valid && redirect_flush_ras;

   always_ff @(posedge clk or posedge RST) begin
      if (RST)
         r_pc <= RESET_PC;
      else if (redirect_valid)
         r_pc <= redirect_pc;
      else if (pc_en)
         r_pc <= w_npc;
   end

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .WIDTH (XLEN)
   ) u_ras (
      .clk       (clk),
      .RST       (RST),
      .push      (w_push),
      .pop       (w_pop),
      .clear     (w_clear),
      .push_data (w_seq),
      .top       (w_ras_top),
      .count     (ras_count),
      .underflow (ras_underflow)
   );

   assign pc         = r_pc;
   assign npc        = w_npc;
   assign misaligned = |w_npc[1:0];

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module  : tb_pc_unit
// Brief   : Directed plus random stimulus for pc_unit against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;

   localparam int c_depth = 4;

   logic        clk = 1'b0;
   logic        RST;
   logic        pc_en;
   logic [2:0]  sel;
   logic [15:0] immd16;
   logic [25:0] immd26;
   logic [31:0] rs;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_flush_ras;
   logic [31:0] pc;
   logic [31:0] npc;
   logic [2:0]  ras_count;
   logic        misaligned;
   logic        ras_underflow;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: return addresses as a bounded list, newest at the back.
   logic [31:0] m_pc;
   logic [31:0] m_ras[$];
   bit          m_uf;

   always #5 clk = ~clk;

   pc_unit #(.XLEN(32), .RESET_PC(32'h0), .RAS_DEPTH(c_depth)) dut (
      .clk                (clk),
      .RST                (RST),
      .pc_en              (pc_en),
      .sel                (sel),
      .immd16             (immd16),
      .immd26             (immd26),
      .rs                 (rs),
      .redirect_valid     (redirect_valid),
      .redirect_pc        (redirect_pc),
      .redirect_flush_ras (redirect_flush_ras),
      .pc                 (pc),
      .npc                (npc),
      .ras_count          (ras_count),
      .misaligned         (misaligned),
      .ras_underflow      (ras_underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_npc(input logic [2:0] s, input logic [15:0] i16,
                                             input logic [25:0] i26, input logic [31:0] r);
      logic [31:0] seq = m_pc + 32'd4;
      int          off = int'($signed(i16)) * 4;
      case (s)
         3'd1, 3'd4: return seq + 32'(off);
         3'd2, 3'd5: return (m_pc & 32'hF000_0000) | (32'(i26) << 2);
         3'd3:       return r;
         3'd6:       return (m_ras.size() > 0) ? m_ras[$] : seq;
         default:    return seq;
      endcase
   endfunction

   task automatic model_reset();
      m_pc = 32'h0;
      m_ras.delete();
      m_uf = 1'b0;
   endtask

   // One clock: drive inputs, check combinational outputs, advance, check state.
   task automatic step(input bit en, input logic [2:0] s, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] r,
                       input bit rv, input logic [31:0] rp, input bit fl);
      logic [31:0] exp_npc;
      pc_en = en; sel = s; immd16 = i16; immd26 = i26; rs = r;
      redirect_valid = rv; redirect_pc = rp; redirect_flush_ras = fl;
      #3;
      exp_npc = model_npc(s, i16, i26, r);
      chk("npc", npc, exp_npc);
      chk("misaligned", 32'(misaligned), 32'(exp_npc[1:0] != 2'b00));
      m_uf = 1'b0;
      if (rv) begin
         m_pc = rp;
         if (fl) m_ras.delete();
      end else if (en) begin
         if (s == 3'd4 || s == 3'd5) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > c_depth) void'(m_ras.pop_front());
         end else if (s == 3'd6) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
            else m_uf = 1'b1;
         end
         m_pc = exp_npc;
      end
      @(posedge clk);
      #1;
      chk("pc", pc, m_pc);
      chk("ras_count", 32'(ras_count), 32'(m_ras.size()));
      chk("ras_underflow", 32'(ras_underflow), 32'(m_uf));
   endtask

   task automatic go(input logic [2:0] s, input logic [15:0] i16, input logic [25:0] i26);
      step(1'b1, s, i16, i26, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic redir(input logic [31:0] rp, input bit fl);
      step(1'b0, 3'd0, 16'h0, 26'h0, 32'h0, 1'b1, rp, fl);
   endtask

   initial begin
      logic [31:0] calls [5];
      RST = 1'b1; pc_en = 1'b0; sel = 3'd0; immd16 = '0; immd26 = '0; rs = '0;
      redirect_valid = 1'b0; redirect_pc = '0; redirect_flush_ras = 1'b0;
      model_reset();
      #2;
      chk("reset_pc", pc, 32'h0);
      chk("reset_count", 32'(ras_count), 32'h0);
      chk("reset_uf", 32'(ras_underflow), 32'h0);
      @(posedge clk);
      #1;
      RST = 1'b0;

      // Sequential fetch from reset.
      for (int i = 0; i < 3; i++) go(3'd0, 16'h0, 26'h0);
      chk("seq_pc12", pc, 32'd12);

      // Relative branch back by one word, then absolute jump in region.
      redir(32'h100, 1'b0);
      go(3'd1, 16'hFFFF, 26'h0);
      chk("rel_pc", pc, 32'h100);
      redir(32'h4000_0010, 1'b0);
      go(3'd2, 16'h0, 26'h10);
      chk("abs_pc", pc, 32'h4000_0040);

      // Call then immediate return.
      redir(32'h200, 1'b1);
      go(3'd5, 16'h0, 26'h100);
      chk("call_pc", pc, 32'h400);
      go(3'd6, 16'h0, 26'h0);
      chk("ret_pc", pc, 32'h204);

      // Five calls into a four-deep stack, then five returns.
      for (int k = 0; k < 5; k++) begin
         calls[k] = 32'h1000 * (k + 1) + 32'h20;
         redir(calls[k], 1'b0);
         go(3'd4, 16'h0010, 26'h0);
      end
      for (int k = 0; k < 4; k++) begin
         go(3'd6, 16'h0, 26'h0);
         chk("ret_order", pc, calls[4-k] + 32'd4);
      end
      go(3'd6, 16'h0, 26'h0);
      chk("uf_pulse", 32'(ras_underflow), 32'h1);
      go(3'd0, 16'h0, 26'h0);

      // Redirect with flush beats a concurrent call.
      go(3'd4, 16'h0, 26'h0);
      step(1'b1, 3'd4, 16'h0, 26'h0, 32'h0, 1'b1, 32'h80, 1'b1);
      chk("redir_pc", pc, 32'h80);
      chk("redir_cnt", 32'(ras_count), 32'h0);

      // Stall holds a pending return, then asynchronous reset mid-cycle.
      go(3'd4, 16'h0, 26'h0);
      go(3'd4, 16'h0, 26'h0);
      step(1'b0, 3'd6, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("stall_cnt", 32'(ras_count), 32'h2);
      #2;
      RST = 1'b1;
      model_reset();
      #1;
      chk("async_rst_pc", pc, 32'h0);
      chk("async_rst_cnt", 32'(ras_count), 32'h0);
      @(posedge clk);
      #1;
      chk("rst_hold_pc", pc, 32'h0);
      RST = 1'b0;

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         bit          rv = ($urandom_range(15) == 0);
         logic [31:0] r  = $urandom;
         if ($urandom_range(1)) r[1:0] = 2'b00;
         step($urandom_range(3) != 0, 3'($urandom_range(7)), 16'($urandom),
              26'($urandom), r, rv, {$urandom_range(32'h3FFF_FFFF), 2'b00},
              $urandom_range(1) == 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
